// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial add/subtract controller:
// digit width and maximum value, the digit type, the controller state
// encoding and the 9's-complement helper used by the digit slice.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // 9's complement of one BCD digit; only meaningful for digits 0..9.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_slice.sv
// One-digit BCD add/subtract slice (purely combinational).
// sub=1 replaces b by its 9's complement, so that with carry-in set
// the slice contributes one digit of A + 10's complement of B.
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       sub_i,
    input  logic       cin_i,
    output bcd_digit_t sum_o,
    output logic       cout_o
);

    bcd_digit_t b_sel_s;
    logic [4:0] bin_sum_s;

    assign b_sel_s   = sub_i ? nines_comp(b_i) : b_i;
    assign bin_sum_s = {1'b0, a_i} + {1'b0, b_sel_s} + {4'b0000, cin_i};

    // Decimal correction: binary sums above 9 wrap by adding 6 and carry out.
    always_comb begin
        sum_o  = bin_sum_s[3:0];
        cout_o = 1'b0;
        if (bin_sum_s > 5'd9) begin
            sum_o  = bin_sum_s[3:0] + 4'd6;
            cout_o = 1'b1;
        end else begin
            sum_o  = bin_sum_s[3:0];
            cout_o = 1'b0;
        end
    end

endmodule : bcd_digit_slice

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial multi-digit BCD add/subtract sequencer.
// Latches A, B and mode on an accepted start, runs one digit per cycle
// (least significant first) through a single bcd_digit_slice, rippling
// the carry through a register, then pulses done for one cycle.
// Optional feature macro: BCD_INVALID_CHECK_EN adds an 'invalid' output
// flagging any latched operand digit above 9.
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W*DIGITS-1:0] result,
    output logic                  cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                  invalid
`endif
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    ctrl_state_t      state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic             mode_q,   mode_d;
    logic [W-1:0]     opa_q,    opa_d;
    logic [W-1:0]     opb_q,    opb_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;

    logic             accept_s;
    bcd_digit_t       slice_a_s;
    bcd_digit_t       slice_b_s;
    bcd_digit_t       slice_sum_s;
    logic             slice_cout_s;

    // A new operation is taken only when no digits are in flight.
    assign accept_s  = start && ((state_q == IDLE) || (state_q == DONE));

    assign slice_a_s = opa_q[idx_q*BCD_W +: BCD_W];
    assign slice_b_s = opb_q[idx_q*BCD_W +: BCD_W];

    bcd_digit_slice u_slice (
        .a_i    (slice_a_s),
        .b_i    (slice_b_s),
        .sub_i  (mode_q),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .cout_o (slice_cout_s)
    );

    // Next-state logic: operand latch on accept, one digit per RUN cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    opa_d    = a;
                    opb_d    = b;
                    mode_d   = mode;
                    idx_d    = '0;
                    carry_d  = mode;
                    result_d = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                result_d[idx_q*BCD_W +: BCD_W] = slice_sum_s;
                carry_d = slice_cout_s;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout_s;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    logic invalid_q, invalid_d;

    // Sticky flag for non-BCD digits seen during RUN, cleared on accept.
    always_comb begin
        invalid_d = invalid_q;
        if (accept_s) begin
            invalid_d = 1'b0;
        end else if ((state_q == RUN) &&
                     ((slice_a_s > BCD_MAX) || (slice_b_s > BCD_MAX))) begin
            invalid_d = 1'b1;
        end else begin
            invalid_d = invalid_q;
        end
    end

    // Invalid-digit flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_q <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;
`endif

    // Status outputs decode directly from the state register.
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule : bcd_serial_addsub_ctrl
